// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the fetch/data RAM arbiter
package mem_port_arbiter_pkg;
    localparam int MEM_AW_DEF     = 12;
    localparam int STARVE_MAX_DEF = 3;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;
endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// mem_port_arbiter_starve_cnt: saturating count of consecutive denied fetch cycles
module mem_port_arbiter_starve_cnt #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_cnt <= '0;
        else if (i_inc && !o_sat) r_cnt <= r_cnt + 4'd1;
    end
    assign o_sat = r_cnt == 4'(MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-priority share of one sync RAM between fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_wren,
    input  logic [31:0]       d_wrdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_wren,
    output logic [31:0]       mem_wrdata,
    input  logic [31:0]       mem_rdata
);
    owner_t r_owner;
    logic   w_sat;
    logic   w_unused;

    mem_port_arbiter_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_inc (if_req && !if_gnt),
        .i_clr (if_gnt || !if_req),
        .o_sat (w_sat)
    );

    always_comb begin
        if_gnt     = !rst && if_req && (!d_req || w_sat);
        d_gnt      = !rst && d_req && !if_gnt;
        mem_en     = if_gnt || d_gnt;
        mem_addr   = if_gnt ? if_addr[MEM_AW+1:2] : d_gnt ? d_addr[MEM_AW+1:2] : '0;
        mem_wren   = d_gnt ? d_wren : 4'b0;
        mem_wrdata = d_wrdata;
    end

    always_ff @(posedge clk) begin
        if (rst) r_owner <= OWN_NONE;
        else r_owner <= if_gnt ? OWN_IF : (d_gnt && d_wren == 4'b0) ? OWN_D : OWN_NONE;
    end

    // Masking with rst drops a response whose grant preceded the reset cycle.
    always_comb begin
        if_rvalid = !rst && r_owner == OWN_IF;
        d_rvalid  = !rst && r_owner == OWN_D;
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid ? mem_rdata : 32'h0;
    end

    assign w_unused = &{1'b0, if_addr[31:MEM_AW+2], if_addr[1:0], d_addr[31:MEM_AW+2], d_addr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation, wrap and reset behaviour
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        if_req = 0, d_req = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wrdata = 0;
    logic [3:0]  d_wren = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
    logic [31:0] if_rdata, d_rdata, mem_wrdata;
    logic [31:0] mem_rdata = 0;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wren;
    logic [31:0] ram [0:4095];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_AW(12), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wren(d_wren), .d_wrdata(d_wrdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wrdata(mem_wrdata),
        .mem_rdata(mem_rdata)
    );

    // RAM model: preloaded with 0x5A5A_0000 + word index while rst is high
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'h5A5A_0000 + i;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) if (mem_wren[b]) ram[mem_addr][8*b+:8] <= mem_wrdata[8*b+:8];
            if (mem_wren == 4'b0) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic test_reset();
        rst = 1; if_req = 1; d_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin $display("FAIL reset_gnt got %b exp 000", {if_gnt, d_gnt, mem_en}); bad++; end
        total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin $display("FAIL reset_rvalid got %b exp 00", {if_rvalid, d_rvalid}); bad++; end
        total++; if ({if_rdata, d_rdata} !== 64'h0) begin $display("FAIL reset_rdata got %h exp 0", {if_rdata, d_rdata}); bad++; end
        total++; if (mem_addr !== 12'h0 || mem_wren !== 4'h0) begin $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_wren); bad++; end
        if_req = 0; d_req = 0; rst = 0;
    endtask

    task automatic test_fetch();
        @(negedge clk); if_req = 1; if_addr = 32'h0000_0010; #1;
        total++; if ({if_gnt, d_gnt, mem_en} !== 3'b101) begin $display("FAIL fetch_gnt got %b exp 101", {if_gnt, d_gnt, mem_en}); bad++; end
        total++; if (mem_addr !== 12'h004 || mem_wren !== 4'h0) begin $display("FAIL fetch_addr got %h/%h exp 004/0", mem_addr, mem_wren); bad++; end
        @(posedge clk); #1;
        total++; if ({if_rvalid, d_rvalid} !== 2'b10) begin $display("FAIL fetch_rvalid got %b exp 10", {if_rvalid, d_rvalid}); bad++; end
        total++; if (if_rdata !== 32'h5A5A_0004 || d_rdata !== 32'h0) begin $display("FAIL fetch_rdata got %h/%h exp 5a5a0004/0", if_rdata, d_rdata); bad++; end
        @(negedge clk); if_req = 0;
    endtask

    task automatic test_write_read();
        @(negedge clk); d_req = 1; d_addr = 32'h20; d_wren = 4'b0011; d_wrdata = 32'hAABB_CCDD; #1;
        total++; if (d_gnt !== 1'b1 || mem_wren !== 4'b0011 || mem_addr !== 12'h008) begin $display("FAIL wr_gnt got %b/%b/%h exp 1/0011/008", d_gnt, mem_wren, mem_addr); bad++; end
        total++; if (mem_wrdata !== 32'hAABB_CCDD) begin $display("FAIL wr_data got %h exp aabbccdd", mem_wrdata); bad++; end
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b0) begin $display("FAIL wr_no_rvalid got %b exp 0", d_rvalid); bad++; end
        @(negedge clk); d_wren = 4'b0; #1;
        total++; if (d_gnt !== 1'b1 || mem_wren !== 4'b0) begin $display("FAIL rd_gnt got %b/%b exp 1/0000", d_gnt, mem_wren); bad++; end
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A5A_CCDD) begin $display("FAIL raw_data got %b/%h exp 1/5a5accdd", d_rvalid, d_rdata); bad++; end
        @(negedge clk); d_req = 0;
    endtask

    task automatic test_starve();
        logic e;
        @(negedge clk); if_req = 1; d_req = 1; d_wren = 0; d_addr = 32'h100; if_addr = 32'h104;
        for (int i = 0; i < 8; i++) begin
            e = (i % 4 == 3);
            #1;
            total++; if (if_gnt !== e || d_gnt !== !e) begin $display("FAIL starve_gnt[%0d] got %b%b exp %b%b", i, if_gnt, d_gnt, e, !e); bad++; end
            @(posedge clk); #1;
            total++; if (if_rvalid !== e || d_rvalid !== !e) begin $display("FAIL starve_rvalid[%0d] got %b%b exp %b%b", i, if_rvalid, d_rvalid, e, !e); bad++; end
            total++; if ((e ? if_rdata : d_rdata) !== (e ? 32'h5A5A_0041 : 32'h5A5A_0040)) begin $display("FAIL starve_rdata[%0d] got %h/%h", i, if_rdata, d_rdata); bad++; end
            @(negedge clk);
        end
        if_req = 0; d_req = 0;
    endtask

    task automatic test_back_to_back();
        logic f;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            f = i[0];
            if_req = f; d_req = !f; #1;
            total++; if (if_gnt !== f || d_gnt !== !f) begin $display("FAIL b2b_gnt[%0d] got %b%b exp %b%b", i, if_gnt, d_gnt, f, !f); bad++; end
            @(posedge clk); #1;
            total++; if (if_rvalid !== f || d_rvalid !== !f) begin $display("FAIL b2b_rvalid[%0d] got %b%b exp %b%b", i, if_rvalid, d_rvalid, f, !f); bad++; end
            total++; if (if_rdata !== (f ? 32'h5A5A_0041 : 32'h0) || d_rdata !== (f ? 32'h0 : 32'h5A5A_0040)) begin $display("FAIL b2b_rdata[%0d] got %h/%h", i, if_rdata, d_rdata); bad++; end
            @(negedge clk);
        end
        if_req = 0; d_req = 0;
    endtask

    task automatic test_wrap();
        @(negedge clk); d_req = 1; d_wren = 0; d_addr = 32'h0001_4008; #1;
        total++; if (mem_addr !== 12'h002 || d_gnt !== 1'b1) begin $display("FAIL wrap_addr got %h/%b exp 002/1", mem_addr, d_gnt); bad++; end
        @(negedge clk); d_addr = 32'h0001_400B; #1;
        total++; if (mem_addr !== 12'h002) begin $display("FAIL wrap_lowbits got %h exp 002", mem_addr); bad++; end
        @(posedge clk); #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A5A_0002) begin $display("FAIL wrap_rdata got %b/%h exp 1/5a5a0002", d_rvalid, d_rdata); bad++; end
        @(negedge clk); d_req = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); if_req = 1; if_addr = 32'h10;
        @(posedge clk); #1; rst = 1; d_req = 1; #1;
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin $display("FAIL rstmid_rvalid got %b/%h exp 0/0", if_rvalid, if_rdata); bad++; end
        total++; if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin $display("FAIL rstmid_gnt got %b exp 000", {if_gnt, d_gnt, mem_en}); bad++; end
        @(negedge clk); #1;
        total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0000) begin $display("FAIL rstmid_hold got %b exp 0000", {if_gnt, d_gnt, if_rvalid, d_rvalid}); bad++; end
        @(negedge clk); rst = 0; #1;
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b1) begin $display("FAIL rstmid_cnt got %b%b exp 01", if_gnt, d_gnt); bad++; end
        @(negedge clk); if_req = 0; d_req = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_starve();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
